// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one ALU between two requesters.
// Round-robin grant in IDLE, operands held on the ALU for SETTLE cycles,
// result captured into a registered response held until the consumer takes it.
// Opcodes outside AND/OR/ADD/SUB/PassB are answered with an error response
// without touching the ALU inputs.
//
// Handshake semantics (all three channels): a transfer happens on the rising
// edge where valid and ready are both high. A producer keeps valid and its
// payload stable until that edge; ready never depends on anything but the
// controller state, the pointer and the request valids, so there is no
// combinational path from ready back into valid.
module alu_share_ctrl #(
  parameter int N      = 64,
  parameter int SETTLE = 3   // legal range 1..15
) (
  input  logic         CLK,
  input  logic         resetl,
  // requester 0
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic [3:0]   req0_op,
  // requester 1
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic [3:0]   req1_op,
  // response
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [N-1:0] rsp_result,
  output logic         rsp_zero,
  output logic         rsp_err,
  // ALU side
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_ctrl,
  input  logic [N-1:0] alu_w,
  input  logic         alu_zero,
  // status
  output logic         busy,
  output logic [1:0]   dbgState
);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_PASSB = 4'b0111;

  // Counter load value: the sampling edge is SETTLE edges after acceptance.
  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } stateT;

  stateT        state;
  stateT        stateNext;
  logic         ptr;        // requester that wins when both are valid
  logic [3:0]   settleCnt;

  logic         pickReq1;
  logic         anyValid;
  logic         accept;
  logic         selLegal;
  logic [N-1:0] selA;
  logic [N-1:0] selB;
  logic [3:0]   selOp;
  logic         sampleNow;

  function automatic logic isLegal(input logic [3:0] op);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_PASSB: ok = 1'b1;
      default:                                 ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Grant selection and operand mux: pointer breaks ties, a lone valid wins.
  always_comb begin
    anyValid  = req0_valid | req1_valid;
    pickReq1  = req1_valid & (~req0_valid | ptr);
    selA      = pickReq1 ? req1_a  : req0_a;
    selB      = pickReq1 ? req1_b  : req0_b;
    selOp     = pickReq1 ? req1_op : req0_op;
    selLegal  = isLegal(selOp);
    accept    = (state == IDLE) & anyValid;
    sampleNow = (state == EXEC) & (settleCnt == 4'd0);
  end

  // Next-state and state-derived outputs; ready only for the granted requester.
  always_comb begin
    stateNext  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp_valid  = 1'b0;
    busy       = 1'b1;
    dbgState   = state;
    case (state)
      IDLE: begin
        busy       = 1'b0;
        req0_ready = req0_valid & ~pickReq1;
        req1_ready = pickReq1;
        if (anyValid) begin
          stateNext = selLegal ? EXEC : RESP;
        end
      end
      EXEC: begin
        if (settleCnt == 4'd0) begin
          stateNext = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Settle counter: loaded on a legal acceptance, counts down while in EXEC.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      settleCnt <= 4'd0;
    end else if (accept && selLegal) begin
      settleCnt <= SETTLE_INIT;
    end else if (state == EXEC && settleCnt != 4'd0) begin
      settleCnt <= settleCnt - 4'd1;
    end
  end

  // ALU input registers: change only on a legal acceptance, otherwise hold.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_ctrl <= OP_PASSB;
    end else if (accept && selLegal) begin
      alu_a    <= selA;
      alu_b    <= selB;
      alu_ctrl <= selOp;
    end
  end

  // Response registers: id on acceptance, error fill for illegal ops,
  // ALU capture on the sampling edge; untouched while RESP waits.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else if (accept) begin
      rsp_id <= pickReq1;
      if (!selLegal) begin
        rsp_result <= '0;
        rsp_zero   <= 1'b0;
        rsp_err    <= 1'b1;
      end
    end else if (sampleNow) begin
      rsp_result <= alu_w;
      rsp_zero   <= alu_zero;
      rsp_err    <= 1'b0;
    end
  end

  // Priority pointer: the requester just served drops to low priority.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      ptr <= 1'b0;
    end else if (state == RESP && rsp_ready) begin
      ptr <= ~rsp_id;
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: directed scenarios plus a randomized phase,
// checked by a transaction-level model (expected response queue, grant
// pointer, latency in cycles) and an ALU model that only shows a correct
// result once its inputs have been stable long enough.
module tb_alu_share_ctrl;

  localparam int N      = 64;
  localparam int SETTLE = 3;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_PASSB = 4'b0111;

  logic         CLK;
  logic         resetl;
  logic         req0_valid, req0_ready;
  logic [N-1:0] req0_a, req0_b;
  logic [3:0]   req0_op;
  logic         req1_valid, req1_ready;
  logic [N-1:0] req1_a, req1_b;
  logic [3:0]   req1_op;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
  logic [N-1:0] rsp_result;
  logic [N-1:0] alu_a, alu_b, alu_w;
  logic [3:0]   alu_ctrl;
  logic         alu_zero;
  logic         busy;
  logic [1:0]   dbgState;

  int checks = 0;
  int errors = 0;

  logic [3:0] legalOps [5] = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_PASSB};

  alu_share_ctrl #(.N(N), .SETTLE(SETTLE)) dut (
    .CLK(CLK), .resetl(resetl),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_w(alu_w), .alu_zero(alu_zero),
    .busy(busy), .dbgState(dbgState)
  );

  // Clock
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic checkVal(input string tag, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  // ---------------- ALU model (environment) ----------------
  function automatic logic [N-1:0] aluFn(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic [3:0] ctrl);
    logic [N-1:0] r;
    case (ctrl)
      OP_AND:   r = a & b;
      OP_OR:    r = a | b;
      OP_ADD:   r = a + b;
      OP_SUB:   r = a - b;
      OP_PASSB: r = b;
      default:  r = 64'hBAD0_BAD0_BAD0_BAD0;
    endcase
    return r;
  endfunction

  // Age of the ALU inputs in cycles; result is garbage until settled.
  logic [2*N+3:0] lastIn;
  int             age = 0;
  logic [N-1:0]   trueW;
  logic           settled;

  initial begin
    lastIn = '0;
    forever begin
      @(posedge CLK);
      #1;
      if ({alu_a, alu_b, alu_ctrl} !== lastIn) begin
        lastIn = {alu_a, alu_b, alu_ctrl};
        age    = 0;
      end else if (age < 1000) begin
        age++;
      end
    end
  end

  assign trueW    = aluFn(alu_a, alu_b, alu_ctrl);
  assign settled  = (age >= SETTLE - 1);
  assign alu_w    = settled ? trueW : ~trueW;
  assign alu_zero = settled ? (trueW == '0) : (trueW != '0);

  // ---------------- reference model ----------------
  // Expected response packed as {id, err, zero, result}.
  function automatic logic [N+2:0] refRsp(input logic id, input logic [N-1:0] a,
                                          input logic [N-1:0] b, input logic [3:0] op);
    logic [N-1:0] r;
    if (op inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_PASSB}) begin
      r = aluFn(a, b, op);
      return {id, 1'b0, (r == '0), r};
    end
    return {id, 1'b1, 1'b0, {N{1'b0}}};
  endfunction

  logic [N+2:0] expQ[$];
  logic         grantLog[$];
  bit           inFlight = 0;
  bit           seen = 0;
  int           waitCnt = 0;
  int           expWait = 0;
  logic         modelPtr = 1'b0;
  logic [N-1:0] mA = '0, mB = '0, pA = '0, pB = '0;
  logic [3:0]   mCtrl = OP_PASSB, pC = OP_PASSB;
  bit           pendUpd = 0;

  // Scoreboard / monitor, sampled on the falling edge.
  always @(negedge CLK) begin
    logic         idleNow, exp0, exp1, gid;
    logic [N-1:0] a, b;
    logic [3:0]   op;
    logic [N+2:0] e;
    if (!resetl) begin
      expQ.delete();
      inFlight = 0;
      seen     = 0;
      modelPtr = 1'b0;
      mA = '0; mB = '0; mCtrl = OP_PASSB;
      pendUpd  = 0;
    end else begin
      if (pendUpd) begin
        mA = pA; mB = pB; mCtrl = pC;
        pendUpd = 0;
      end
      checkVal("alu_hold", {alu_a, alu_b, alu_ctrl}, {mA, mB, mCtrl});
      checkVal("busy", busy, inFlight);
      idleNow = !inFlight;
      exp0 = idleNow && req0_valid && (!req1_valid || !modelPtr);
      exp1 = idleNow && req1_valid && (!req0_valid || modelPtr);
      checkVal("req_ready", {req0_ready, req1_ready}, {exp0, exp1});
      if (inFlight) begin
        waitCnt++;
        if (rsp_valid && !seen) begin
          seen = 1;
          checkVal("rsp_latency", waitCnt, expWait);
        end
        if (rsp_valid) begin
          checkVal("rsp_fields", {rsp_id, rsp_err, rsp_zero, rsp_result}, expQ[0]);
          if (rsp_ready) begin
            e        = expQ.pop_front();
            modelPtr = ~e[N+2];
            inFlight = 0;
          end
        end
      end else if (rsp_valid) begin
        checkVal("rsp_spurious", rsp_valid, 1'b0);
      end
      if (idleNow && (exp0 || exp1)) begin
        gid = exp1;
        a  = gid ? req1_a  : req0_a;
        b  = gid ? req1_b  : req0_b;
        op = gid ? req1_op : req0_op;
        e  = refRsp(gid, a, b, op);
        expQ.push_back(e);
        grantLog.push_back(gid);
        inFlight = 1;
        seen     = 0;
        waitCnt  = 0;
        expWait  = e[N+1] ? 1 : SETTLE + 1;
        if (!e[N+1]) begin
          pA = a; pB = b; pC = op;
          pendUpd = 1;
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic issue(input logic id, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [3:0] op);
    int n;
    bit got;
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
    end
    n   = 0;
    got = 0;
    while (!got && n < 400) begin
      @(negedge CLK);
      n++;
      got = id ? req1_ready : req0_ready;
    end
    if (!got) checkVal(id ? "req1_accept_timeout" : "req0_accept_timeout", 1'b0, 1'b1);
    @(posedge CLK);
    #1;
    if (id) req1_valid = 1'b0;
    else    req0_valid = 1'b0;
  endtask

  task automatic expectRsp(input logic id, input logic err, input logic zero,
                           input logic [N-1:0] result, output int waited);
    waited = 0;
    do begin
      @(negedge CLK);
      waited++;
    end while (!rsp_valid && waited < 50);
    checkVal("rsp_seen", rsp_valid, 1'b1);
    checkVal("rsp_expect", {rsp_id, rsp_err, rsp_zero, rsp_result}, {id, err, zero, result});
  endtask

  task automatic randReq(input logic id, input int nOps);
    int gap;
    logic [N-1:0] a, b;
    logic [3:0] op;
    for (int i = 0; i < nOps; i++) begin
      gap = $urandom_range(0, 3);
      if (gap > 0) begin
        repeat (gap) @(posedge CLK);
        #1;
      end
      if ($urandom_range(0, 9) < 8) op = legalOps[$urandom_range(0, 4)];
      else                          op = 4'($urandom_range(0, 15));
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if ($urandom_range(0, 4) == 0) b = a;
      issue(id, a, b, op);
    end
  endtask

  bit randRdy = 0;

  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (randRdy) rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Watchdog
  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    int w;
    int n;
    logic [N+2:0] snap;
    resetl     = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
    rsp_ready  = 1'b1;
    #2;
    resetl = 1'b0;
    #1;
    checkVal("reset_ctrl", {busy, rsp_valid, rsp_id, rsp_err, rsp_zero}, 5'b0);
    checkVal("reset_alu", {alu_a, alu_b, alu_ctrl}, {64'd0, 64'd0, OP_PASSB});
    checkVal("reset_result", rsp_result, 64'd0);
    repeat (2) @(posedge CLK);
    #3;
    resetl = 1'b1;
    @(posedge CLK);
    #1;

    // Single ADD from requester 0
    issue(1'b0, 64'd5, 64'd7, OP_ADD);
    checkVal("add_alu_inputs", {alu_a, alu_b, alu_ctrl}, {64'd5, 64'd7, OP_ADD});
    expectRsp(1'b0, 1'b0, 1'b0, 64'd12, w);
    checkVal("add_latency", w, SETTLE + 1);
    @(posedge CLK);
    #1;

    // SUB to zero from requester 1
    issue(1'b1, 64'h10, 64'h10, OP_SUB);
    expectRsp(1'b1, 1'b0, 1'b1, 64'd0, w);
    @(posedge CLK);
    #1;

    // Reset in the middle of EXEC
    issue(1'b0, 64'd9, 64'd3, OP_SUB);
    @(negedge CLK);
    #2;
    resetl = 1'b0;
    #1;
    checkVal("midrst_ctrl", {busy, rsp_valid, rsp_id, rsp_err, rsp_zero, req0_ready, req1_ready}, 7'b0);
    checkVal("midrst_alu", {alu_a, alu_b, alu_ctrl}, {64'd0, 64'd0, OP_PASSB});
    checkVal("midrst_result", rsp_result, 64'd0);
    repeat (2) @(posedge CLK);
    #3;
    resetl = 1'b1;
    repeat (4) begin
      @(negedge CLK);
      checkVal("post_rst_quiet", {rsp_valid, busy}, 2'b00);
    end
    @(posedge CLK);
    #1;

    // Illegal opcode right after reset
    issue(1'b0, {N{1'b1}}, {N{1'b1}}, 4'b1111);
    expectRsp(1'b0, 1'b1, 1'b0, 64'd0, w);
    checkVal("illegal_latency", w, 1);
    checkVal("illegal_alu_ctrl", alu_ctrl, OP_PASSB);
    @(posedge CLK);
    #1;

    // Backpressure: both request, response held for 5 cycles
    rsp_ready = 1'b0;
    fork
      issue(1'b1, 64'hF0, 64'h0F, OP_OR);
      issue(1'b0, 64'd1, 64'd2, OP_ADD);
      begin
        n = 0;
        do begin
          @(negedge CLK);
          n++;
        end while (!rsp_valid && n < 50);
        checkVal("bp_rsp_seen", rsp_valid, 1'b1);
        checkVal("bp_id", rsp_id, 1'b1);
        checkVal("bp_result", rsp_result, 64'hFF);
        snap = {rsp_id, rsp_err, rsp_zero, rsp_result};
        repeat (5) begin
          @(negedge CLK);
          checkVal("bp_hold", {rsp_valid, rsp_id, rsp_err, rsp_zero, rsp_result}, {1'b1, snap});
          checkVal("bp_busy_ready", {busy, req0_ready, req1_ready}, 3'b100);
        end
        @(posedge CLK);
        #1;
        rsp_ready = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        checkVal("bp_next_grant", {req0_ready, req1_ready}, 2'b10);
      end
    join

    // Contention: both valid continuously, ready always high
    grantLog.delete();
    fork
      for (int i = 0; i < 4; i++) issue(1'b0, {$urandom, $urandom}, {$urandom, $urandom}, OP_ADD);
      for (int i = 0; i < 4; i++) issue(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, OP_OR);
    join
    repeat (SETTLE + 3) @(negedge CLK);
    checkVal("contention_count", grantLog.size(), 8);
    for (int i = 0; i < grantLog.size(); i++) begin
      checkVal("contention_order", grantLog[i], (i % 2 == 0) ? 1'b1 : 1'b0);
    end
    @(posedge CLK);
    #1;

    // Randomized phase with random response backpressure
    randRdy = 1;
    fork
      randReq(1'b0, 40);
      randReq(1'b1, 40);
    join
    randRdy = 0;
    @(posedge CLK);
    #1;
    rsp_ready = 1'b1;
    n = 0;
    while ((inFlight || expQ.size() != 0) && n < 200) begin
      @(negedge CLK);
      n++;
    end
    checkVal("drain", {inFlight, 32'(expQ.size())}, 33'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Arbitrates one 64-bit ALU instance between two requesters (e.g. main datapath and address/branch-compare unit).
- Sequences each operation: drives ALU operands and ALUCtrl, holds them for a programmable settle window, then captures BusW/Zero into a registered response.
- Sits between the requesters and the ALU ports.
- Owns round-robin fairness, illegal-opcode rejection, and response backpressure.

Parameters:
- N, 64, datapath width (matches ALU n).
- SETTLE, 3, clock cycles the ALU inputs are held before the result is sampled; legal range 1..15.

Ports:
- CLK  input  1  single clock, all state updates on rising edge.
- resetl  input  1  asynchronous, active-low reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 accepted this cycle.
- req0_a, req0_b  input  N  requester 0 operands.
- req0_op  input  4  requester 0 ALUCtrl code.
- req1_valid / req1_ready / req1_a / req1_b / req1_op  same as requester 0, for requester 1.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  consumer takes response.
- rsp_id  output  1  requester served (0/1).
- rsp_result  output  N  captured BusW.
- rsp_zero  output  1  captured Zero.
- rsp_err  output  1  illegal opcode.
- alu_a, alu_b  output  N  to ALU BusA/BusB.
- alu_ctrl  output  4  to ALU ALUCtrl.
- alu_w  input  N  from ALU BusW.
- alu_zero  input  1  from ALU Zero.
- busy  output  1  state != IDLE.

Behaviour:
- Legal ops: AND 0000, OR 0001, ADD 0010, SUB 0110, PassB 0111. Any other code is illegal.
- Reset (resetl low, asynchronous) forces:
  - state IDLE; busy 0.
  - alu_a = 0, alu_b = 0, alu_ctrl = 0111 (PassB).
  - rsp_valid 0, rsp_id 0, rsp_result 0, rsp_zero 0, rsp_err 0.
  - priority pointer = requester 0; settle counter 0.
  - An in-flight operation is discarded with no response. Requesters must reissue.
- States: IDLE, EXEC, RESP.
- IDLE:
  - If both valid, grant the pointer's requester. If one valid, grant it.
  - reqX_ready is combinational, high only in IDLE and only for the granted requester. The other ready stays 0.
  - Acceptance edge = edge where valid & ready.
  - Legal op: latch operands/op into alu_a/alu_b/alu_ctrl, latch rsp_id, load counter = SETTLE-1, go to EXEC.
  - Illegal op: leave alu_* unchanged; set rsp_result = 0, rsp_zero = 0, rsp_err = 1, rsp_id; go directly to RESP.
- EXEC:
  - alu_* held constant.
  - If counter = 0: capture rsp_result <= alu_w, rsp_zero <= alu_zero, rsp_err <= 0; go to RESP. Otherwise decrement.
  - Sampling edge = acceptance edge + SETTLE.
- RESP:
  - rsp_valid = 1, and rsp_* held stable until rsp_ready.
  - On the edge with rsp_ready: go to IDLE, and set pointer = complement of rsp_id (served requester loses priority).
  - alu_* keep last values; they change only at the next acceptance.
- Latency:
  - Legal op: rsp_valid high in the cycle after edge E0+SETTLE (E0 = acceptance edge).
  - Illegal op: rsp_valid high in the cycle after E0.
- Throughput: at most one op per SETTLE+2 cycles (IDLE, SETTLE×EXEC, RESP), assuming rsp_ready is always high.
- No new request is accepted while busy; requesters hold valid and stable operands until ready.
- Requester changing operands while not ready: ignored; only values at acceptance matter.
- rsp_ready while rsp_valid is 0: ignored.
- The pointer updates only on response completion, never on a reset-discarded op.

Test Plan:
- Reset mid-EXEC: assert resetl=0 → all outputs return to reset values immediately; after release, no rsp_valid until a new request.
- Single ADD, SETTLE=3: req0 a=5 b=7 op=0010 accepted at edge E0 → alu_a=5, alu_b=7, alu_ctrl=0010 from E0. At E0+3, rsp_valid=1 with result=12, zero=0, id=0, err=0.
- SUB to zero: req1 a=0x10 b=0x10 op=0110 → rsp_result=0, rsp_zero=1, rsp_id=1.
- Contention: both valid continuously, ops ADD/OR, rsp_ready=1 → grants alternate 0,1,0,1. Each response id matches the grant. The non-granted ready is never high.
- Illegal op 1111 from req0 → rsp_valid the cycle after acceptance, with err=1, result=0, zero=0. alu_ctrl keeps its previous value (0111 after reset).
- Backpressure: rsp_ready=0 for 5 cycles in RESP → rsp_* stable, busy=1, both ready=0. Raising rsp_ready → IDLE next cycle, and the next grant goes to the other requester.
